tail_sprite_drawer: RTL and testbench
=====================================

// Module: tail_sprite_drawer
// PURPOSE
//  Drives the 16x16 plasma-tail sprite ROM and consumes its row bits to produce a per-pixel "tail on" flag.
//  Sits between the VGA timing counters and the colour mux, behind the player ship.
//  Owns the 4-frame animation sequencer (ignite / run / cooldown) and the 2-stage pixel pipeline that
//  absorbs the ROM lookup.
// PARAMETERS
//  FRAME_DIV    4  frame_tick pulses per animation-frame advance (>=1)
//  COOL_FRAMES  8  frame_tick pulses the tail stays lit (frame 0 only) after enable drops (>=1)
//  SCALE_LOG2   0  sprite magnification: 2**SCALE_LOG2 screen pixels per sprite pixel (0..2)
// PORTS
//  clk         in   1   pixel clock
//  rst         in   1   asynchronous, active-high reset
//  frame_tick  in   1   one-cycle pulse per VGA frame (start of vblank)
//  enable      in   1   engine thrust request, level
//  pos_x       in   10  sprite top-left column, screen pixels
//  pos_y       in   10  sprite top-left row, screen pixels
//  pixel_x     in   10  current pixel column from VGA timing
//  pixel_y     in   10  current pixel row from VGA timing
//  rom_y       out  4   row address to tail ROM
//  rom_frame   out  2   animation frame to tail ROM
//  rom_bits    in   16  row bits returned by ROM (combinational, same cycle as rom_y)
//  pixel_on    out  1   tail pixel lit at the pixel presented 2 cycles earlier
//  active      out  1   1 while state != OFF
// BEHAVIOUR
//  Reset (async): state=OFF, div_cnt=0, cool_cnt=0, rom_frame=0, rom_y=0, pixel_on=0, active=0,
//   all pipeline registers 0.
//  FSM (clk edge):
//   OFF  -> RUN on enable=1. div_cnt cleared, rom_frame=0.
//   RUN  -> COOL on enable=0. cool_cnt cleared, rom_frame forced 0.
//        On frame_tick: div_cnt++. When div_cnt==FRAME_DIV-1: div_cnt=0, rom_frame++ (3 wraps to 0).
//   COOL -> RUN on enable=1 (div_cnt cleared, rom_frame=0).
//        Else on frame_tick: cool_cnt++. When cool_cnt==COOL_FRAMES-1 -> OFF.
//  Priority:
//   - An enable change in the same cycle as frame_tick: the transition wins; the tick is discarded.
//   - rom_frame changes only on a clock edge, never mid-cycle.
//  Geometry (11-bit unsigned, no wrap):
//   - dx = pixel_x - pos_x; dy = pixel_y - pos_y.
//   - in_box = pixel_x>=pos_x && pixel_y>=pos_y && dx<(16<<SCALE_LOG2) && dy<(16<<SCALE_LOG2).
//   - pos_x/pos_y near 639/479 clip naturally; no part of the sprite appears at column/row 0.
//   - col = dx>>SCALE_LOG2; row = dy>>SCALE_LOG2.
//  Pipeline:
//   - S1 (edge 1): register in_box_q, col_q[3:0], rom_y<=row[3:0] (rom_y<=0 when !in_box).
//   - ROM is combinational on rom_y/rom_frame.
//   - S2 (edge 2): pixel_on <= in_box_q & active & rom_bits[15-col_q].
//   - Latency: exactly 2 clk from pixel_x/pixel_y/pos_x/pos_y to pixel_on. Throughput: 1 pixel/clk.
//  Column order: column 0 (leftmost) = rom_bits[15]; column 15 = rom_bits[0].
//  active = (state!=OFF), registered. OFF forces pixel_on=0 from the next edge.
//  rom_frame changing between S1 and S2: S2 uses the ROM word for the new frame (accepted; only at
//   frame_tick, i.e. during blanking).
//  Reset mid-line: pixel_on drops to 0 immediately (async); pipeline refills after release, first
//   valid pixel_on 2 clk later.
// TESTING
//  T1:
//   - Stimulus: rst, enable=1, pos=(100,200), frame 0, pixel (115,207).
//   - Response: rom_y=7; pixel_on=1 after 2 clk (bits 0x00FF, col15).
//   - Pixel (107,207) -> pixel_on=0; pixel (108,207) -> pixel_on=1.
//  T2:
//   - Stimulus: enable=1; 4 frame_ticks.
//   - Response: rom_frame=1. 16 ticks total -> rom_frame=0 (wrap). Tick+enable fall in one cycle
//     -> COOL, rom_frame=0.
//  T3:
//   - Stimulus: enable falls in RUN, frame 2.
//   - Response: rom_frame=0 next edge; active=1 for 8 frame_ticks, then 0; pixel_on stays 0 after.
//   - Re-assert enable at tick 5 -> RUN, cool aborted.
//  T4:
//   - Stimulus: pos=(630,470), pixel (639,479).
//   - Response: in_box, rom_y=9, col9.
//   - Pixel (5,5) -> pixel_on=0 (no wrap).
//   - SCALE_LOG2=1, pos=(100,200), pixel (131,215) -> rom_y=7, col15.
//  T5:
//   - Stimulus: async rst pulse mid-line while pixel_on=1.
//   - Response: pixel_on=0, rom_frame=0, active=0 without a clk edge; after release with enable=1,
//     pixel_on valid 2 clk later.
//  T6:
//   - Stimulus: enable=0 from reset, sweep full 640x480 frame.
//   - Response: pixel_on never 1, rom_frame stays 0.

Source files
------------

// File: rtl/tail_sprite_drawer.sv
// Plasma-tail sprite drawer: ignite/run/cooldown animation sequencer plus a
// two-stage pixel pipeline wrapped around a combinational 16x16 sprite ROM.
module tail_sprite_drawer #(
  parameter int FRAME_DIV   = 4,
  parameter int COOL_FRAMES = 8,
  parameter int SCALE_LOG2  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick_i,
  input  logic        enable_i,
  input  logic [9:0]  pos_x_i,
  input  logic [9:0]  pos_y_i,
  input  logic [9:0]  pixel_x_i,
  input  logic [9:0]  pixel_y_i,
  output logic [3:0]  rom_y_o,
  output logic [1:0]  rom_frame_o,
  input  logic [15:0] rom_bits_i,
  output logic        pixel_on_o,
  output logic        active_o
);

  localparam int DIV_W  = (FRAME_DIV   > 1) ? $clog2(FRAME_DIV)   : 1;
  localparam int COOL_W = (COOL_FRAMES > 1) ? $clog2(COOL_FRAMES) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(FRAME_DIV - 1);
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOL_FRAMES - 1);
  localparam logic [10:0]       SPAN      = 11'(16 << SCALE_LOG2);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_COOL = 2'd2
  } state_t;

  state_t              state_q;
  logic [DIV_W-1:0]    div_cnt_q;
  logic [COOL_W-1:0]   cool_cnt_q;
  logic [1:0]          rom_frame_q;
  logic                active_q;

  logic [10:0]         dx_d;
  logic [10:0]         dy_d;
  logic                in_box_d;
  logic [3:0]          col_d;
  logic [3:0]          rom_y_d;

  logic                in_box_q;
  logic [3:0]          col_q;
  logic [3:0]          rom_y_q;
  logic                pixel_on_q;

  // Animation sequencer; an enable change always beats a coincident frame_tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_OFF;
      div_cnt_q   <= '0;
      cool_cnt_q  <= '0;
      rom_frame_q <= 2'd0;
      active_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (enable_i) begin
            state_q     <= ST_RUN;
            div_cnt_q   <= '0;
            rom_frame_q <= 2'd0;
            active_q    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!enable_i) begin
            state_q     <= ST_COOL;
            cool_cnt_q  <= '0;
            rom_frame_q <= 2'd0;
          end else if (frame_tick_i) begin
            if (div_cnt_q == DIV_LAST) begin
              div_cnt_q   <= '0;
              rom_frame_q <= rom_frame_q + 2'd1;
            end else begin
              div_cnt_q <= div_cnt_q + DIV_W'(1);
            end
          end
        end
        ST_COOL: begin
          if (enable_i) begin
            state_q     <= ST_RUN;
            div_cnt_q   <= '0;
            rom_frame_q <= 2'd0;
          end else if (frame_tick_i) begin
            if (cool_cnt_q == COOL_LAST) begin
              state_q    <= ST_OFF;
              cool_cnt_q <= '0;
              active_q   <= 1'b0;
            end else begin
              cool_cnt_q <= cool_cnt_q + COOL_W'(1);
            end
          end
        end
        default: begin
          state_q  <= ST_OFF;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  // Sprite-relative geometry; the >= guards stop an underflowed dx/dy wrapping into the box.
  always_comb begin
    dx_d     = {1'b0, pixel_x_i} - {1'b0, pos_x_i};
    dy_d     = {1'b0, pixel_y_i} - {1'b0, pos_y_i};
    in_box_d = (pixel_x_i >= pos_x_i) && (pixel_y_i >= pos_y_i) &&
               (dx_d < SPAN) && (dy_d < SPAN);
    col_d    = 4'(dx_d >> SCALE_LOG2);
    if (in_box_d) begin
      rom_y_d = 4'(dy_d >> SCALE_LOG2);
    end else begin
      rom_y_d = 4'd0;
    end
  end

  // S1 addresses the ROM; S2 picks the column bit (column 0 is the MSB).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_box_q   <= 1'b0;
      col_q      <= 4'd0;
      rom_y_q    <= 4'd0;
      pixel_on_q <= 1'b0;
    end else begin
      in_box_q   <= in_box_d;
      col_q      <= col_d;
      rom_y_q    <= rom_y_d;
      pixel_on_q <= in_box_q & active_q & rom_bits_i[4'd15 - col_q];
    end
  end

  assign rom_y_o     = rom_y_q;
  assign rom_frame_o = rom_frame_q;
  assign pixel_on_o  = pixel_on_q;
  assign active_o    = active_q;

endmodule

// File: tb/tb_tail_sprite_drawer.sv
// Bench for tail_sprite_drawer: geometry vector table, animation/cooldown and
// async-reset sequences, a frame sweep and a randomized run against a reference model.
module tb_tail_sprite_drawer;

  localparam int FD = 4;
  localparam int CF = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        enable;
  logic [9:0]  pos_x, pos_y, pixel_x, pixel_y;
  logic [3:0]  rom_y, rom_y2;
  logic [1:0]  rom_frame, rom_frame2;
  logic [15:0] rom_bits, rom_bits2;
  logic        pixel_on, pixel_on2, active, active2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: run/cool tick counts rather than divider registers.
  int m_state;   // 0 = off, 1 = run, 2 = cool
  int m_run_ticks;
  int m_cool_ticks;
  bit p_inb;
  int p_row, p_col;

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_fn(input logic [1:0] f, input logic [3:0] r);
    case (f)
      2'd0:    rom_fn = (r < 4'd8) ? 16'h00FF : 16'h0FF0;
      2'd1:    rom_fn = 16'hAAAA ^ {r, 12'h000};
      2'd2:    rom_fn = 16'h5555 ^ {12'h000, r};
      default: rom_fn = 16'hFFFF >> r;
    endcase
  endfunction

  assign rom_bits  = rom_fn(rom_frame,  rom_y);
  assign rom_bits2 = rom_fn(rom_frame2, rom_y2);

  tail_sprite_drawer #(.FRAME_DIV(FD), .COOL_FRAMES(CF), .SCALE_LOG2(0)) dut (
    .clk(clk), .rst(rst), .frame_tick_i(frame_tick), .enable_i(enable),
    .pos_x_i(pos_x), .pos_y_i(pos_y), .pixel_x_i(pixel_x), .pixel_y_i(pixel_y),
    .rom_y_o(rom_y), .rom_frame_o(rom_frame), .rom_bits_i(rom_bits),
    .pixel_on_o(pixel_on), .active_o(active));

  tail_sprite_drawer #(.FRAME_DIV(FD), .COOL_FRAMES(CF), .SCALE_LOG2(1)) dut2 (
    .clk(clk), .rst(rst), .frame_tick_i(frame_tick), .enable_i(enable),
    .pos_x_i(pos_x), .pos_y_i(pos_y), .pixel_x_i(pixel_x), .pixel_y_i(pixel_y),
    .rom_y_o(rom_y2), .rom_frame_o(rom_frame2), .rom_bits_i(rom_bits2),
    .pixel_on_o(pixel_on2), .active_o(active2));

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_frame();
    return (m_state == 1) ? (m_run_ticks / FD) % 4 : 0;
  endfunction

  task automatic geom(input int px, input int py, input int ox, input int oy, input int scale,
                      output bit inb, output int row, output int col);
    int span;
    span = 16 << scale;
    inb  = (px >= ox) && (py >= oy) && (px - ox < span) && (py - oy < span);
    row  = inb ? (py - oy) >> scale : 0;
    col  = inb ? (px - ox) >> scale : 0;
  endtask

  task automatic model_reset();
    m_state = 0; m_run_ticks = 0; m_cool_ticks = 0;
    p_inb = 1'b0; p_row = 0; p_col = 0;
  endtask

  // One clock edge: predict from the inputs presented now, then compare after the edge.
  task automatic tick();
    bit          inb;
    int          row, col;
    logic [15:0] w;
    logic        exp_pix;
    geom(int'(pixel_x), int'(pixel_y), int'(pos_x), int'(pos_y), 0, inb, row, col);
    w       = rom_fn(2'(m_frame()), 4'(p_row));
    exp_pix = p_inb && (m_state != 0) && w[15 - p_col];
    if (m_state == 0) begin
      if (enable) begin m_state = 1; m_run_ticks = 0; end
    end else if (m_state == 1) begin
      if (!enable) begin m_state = 2; m_cool_ticks = 0; end
      else if (frame_tick) m_run_ticks++;
    end else begin
      if (enable) begin m_state = 1; m_run_ticks = 0; end
      else if (frame_tick) begin
        m_cool_ticks++;
        if (m_cool_ticks == CF) m_state = 0;
      end
    end
    p_inb = inb; p_row = row; p_col = col;
    @(posedge clk); #1;
    check("model_rom_y",     16'(rom_y),     16'(inb ? row : 0));
    check("model_rom_frame", 16'(rom_frame), 16'(m_frame()));
    check("model_active",    16'(active),    16'(m_state != 0));
    check("model_pixel_on",  16'(pixel_on),  16'(exp_pix));
  endtask

  task automatic pulse(input int idle);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    repeat (idle) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_pix(input int ox, input int oy, input int px, input int py);
    pos_x = 10'(ox); pos_y = 10'(oy); pixel_x = 10'(px); pixel_y = 10'(py);
  endtask

  typedef struct {
    int ox, oy, px, py;
    int ey;
    bit eon;
  } vec_t;

  vec_t tbl[10];
  int   hits;

  initial begin
    tbl[0] = '{100, 200, 115, 207,  7, 1'b1};
    tbl[1] = '{100, 200, 107, 207,  7, 1'b0};
    tbl[2] = '{100, 200, 108, 207,  7, 1'b1};
    tbl[3] = '{630, 470, 639, 479,  9, 1'b1};
    tbl[4] = '{630, 470,   5,   5,  0, 1'b0};
    tbl[5] = '{100, 200,  99, 207,  0, 1'b0};
    tbl[6] = '{100, 200, 116, 207,  0, 1'b0};
    tbl[7] = '{100, 200, 100, 200,  0, 1'b0};
    tbl[8] = '{100, 200, 104, 215, 15, 1'b1};
    tbl[9] = '{  0,   0,  15,  12, 12, 1'b0};

    rst = 1'b0; frame_tick = 1'b0; enable = 1'b0;
    set_pix(0, 0, 320, 240);
    do_reset();
    #1;
    check("reset_rom_y",     16'(rom_y),     16'd0);
    check("reset_rom_frame", 16'(rom_frame), 16'd0);
    check("reset_pixel_on",  16'(pixel_on),  16'd0);
    check("reset_active",    16'(active),    16'd0);

    // Geometry table, frame 0, running.
    enable = 1'b1;
    tick();
    foreach (tbl[i]) begin
      set_pix(tbl[i].ox, tbl[i].oy, tbl[i].px, tbl[i].py);
      tick();
      check("tbl_rom_y", 16'(rom_y), 16'(tbl[i].ey));
      tick();
      check("tbl_pixel_on", 16'(pixel_on), 16'(tbl[i].eon));
    end

    // Magnified instance: 2x2 screen pixels per sprite pixel.
    set_pix(100, 200, 131, 215);
    tick();
    check("x2_rom_y_in", 16'(rom_y2), 16'd7);
    tick();
    check("x2_pixel_on_in", 16'(pixel_on2), 16'd1);
    check("x2_active",      16'(active2),   16'd1);
    check("x2_rom_frame",   16'(rom_frame2), 16'd0);
    set_pix(100, 200, 132, 215);
    tick();
    check("x2_rom_y_out", 16'(rom_y2), 16'd0);
    tick();
    check("x2_pixel_on_out", 16'(pixel_on2), 16'd0);

    // Animation advance, wrap, then tick + enable fall in the same cycle.
    do_reset();
    enable = 1'b1;
    tick();
    repeat (4) pulse(2);
    check("anim_frame1", 16'(rom_frame), 16'd1);
    repeat (12) pulse(1);
    check("anim_wrap", 16'(rom_frame), 16'd0);
    repeat (8) pulse(1);
    check("anim_frame2", 16'(rom_frame), 16'd2);
    frame_tick = 1'b1; enable = 1'b0;
    tick();
    frame_tick = 1'b0;
    check("cool_frame0", 16'(rom_frame), 16'd0);
    check("cool_active", 16'(active), 16'd1);

    // Cooldown lasts exactly CF ticks; the discarded tick above must not count.
    set_pix(100, 200, 115, 207);
    for (int k = 1; k < CF; k++) begin
      pulse(2);
      check("cool_still_active", 16'(active), 16'd1);
    end
    pulse(2);
    check("cool_expired", 16'(active), 16'd0);
    repeat (3) tick();
    check("off_pixel_dark", 16'(pixel_on), 16'd0);

    // Re-enable during cooldown on the 5th tick aborts the cooldown.
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    repeat (4) pulse(1);
    frame_tick = 1'b1; enable = 1'b1;
    tick();
    frame_tick = 1'b0;
    check("reignite_active", 16'(active), 16'd1);
    repeat (4) pulse(1);
    check("reignite_frame1", 16'(rom_frame), 16'd1);

    // Async reset mid-line while lit (frame 1, row 7, col 14).
    set_pix(100, 200, 114, 207);
    tick(); tick();
    check("pre_rst_lit", 16'(pixel_on), 16'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_pixel_on",  16'(pixel_on),  16'd0);
    check("async_rom_frame", 16'(rom_frame), 16'd0);
    check("async_active",    16'(active),    16'd0);
    rst = 1'b0;
    model_reset();
    tick();
    check("refill_edge1", 16'(pixel_on), 16'd0);
    tick();
    check("refill_edge2", 16'(pixel_on), 16'd1);

    // Disabled from reset: subsampled frame sweep must stay dark.
    do_reset();
    enable = 1'b0;
    hits = 0;
    for (int y = 0; y < 480; y += 8) begin
      for (int x = 0; x < 640; x += 4) begin
        set_pix(300, 200, x, y);
        frame_tick = (x == 0);
        tick();
        if (pixel_on !== 1'b0 || rom_frame !== 2'd0) hits++;
      end
    end
    frame_tick = 1'b0;
    check("sweep_dark", 16'(hits), 16'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int ox, oy;
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      frame_tick = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 63) == 0) begin
        pos_x = 10'($urandom_range(0, 639));
        pos_y = 10'($urandom_range(0, 479));
      end
      ox = int'(pos_x);
      oy = int'(pos_y);
      pixel_x = 10'(ox + int'($urandom_range(0, 24)) - 4);
      pixel_y = 10'(oy + int'($urandom_range(0, 24)) - 4);
      tick();
    end
    frame_tick = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
